adc_sample_capture: RTL and testbench
=====================================

# adc_sample_capture

Captures parallel ADC conversion results into an on-chip sample buffer, using the ADC sample clock produced by the PWM/ADC-clock generator as the sampling strobe. It sits directly downstream of that generator, next to the external ADC's data bus, and hands a completed frame of samples to the readout/processing logic through a synchronous read port.

## Interface
- DATA_W, 12, ADC data width in bits.
- DEPTH, 256, buffer depth in samples; must be a power of 2.
- ADDR_W, $clog2(DEPTH), buffer address width; derived, not overridden.
- clk  input  1  system clock; same domain as the ADC clock generator.
- rstn  input  1  reset, asynchronous, active-low.
- adc_clk  input  1  ADC sample clock; registered output of the ADC clock generator in the clk domain.
- adc_data  input  DATA_W  ADC parallel output; asynchronous to clk, stable around the adc_clk falling edge.
- start  input  1  one-cycle pulse that begins a capture; ignored while busy.
- num_samples  input  ADDR_W+1  frame length, sampled on an accepted start.
- trig_level  input  DATA_W  trigger threshold; present only with ADC_CAPTURE_TRIG_EN.
- busy  output  1  high in ARM and CAPTURE.
- done  output  1  level; high from frame completion until the next accepted start.
- wr_count  output  ADDR_W+1  number of samples written in the current or last frame.
- rd_addr  input  ADDR_W  readout address.
- rd_data  output  DATA_W  buffer word at rd_addr, one-cycle latency.

## Operation
- adc_data is registered every clk into adc_data_q.
- adc_clk is registered into adc_clk_q. A sample strobe samp_stb = adc_clk_q & ~adc_clk marks the falling edge.
- FSM states: IDLE, ARM, CAPTURE.
  - IDLE: if start arrives, latch the frame length, clear wr_count, clear done, go to ARM.
  - ARM: on samp_stb, store adc_data_q at address 0, set wr_count=1, go to CAPTURE. If the frame length is 1, go straight to IDLE and set done. With ADC_CAPTURE_TRIG_EN, see Configuration.
  - CAPTURE: on each samp_stb, write adc_data_q at address wr_count and increment wr_count. When the written count reaches the frame length, go to IDLE and set done on the same edge as the final write.
- Frame length: num_samples==0 or num_samples>DEPTH are both clamped to DEPTH.
- start while busy is ignored; the latched frame length is unchanged.
- start in the same cycle that done would be set: the frame completes first, and start is taken only in IDLE on a later cycle.
- Reads are legal in every state and return the current memory contents, including stale data during capture. A read and write to the same address in the same cycle returns the old data.
- Reset: FSM=IDLE, busy=0, done=0, wr_count=0, rd_data=0, adc_clk_q=0, adc_data_q=0. Memory is not cleared. Reset mid-capture aborts the frame with done=0.

## Timing
- adc_clk falls between cycles n-1 and n. samp_stb is high in cycle n, and the memory write and wr_count update occur at the end of cycle n.
- The adc_data value stored is the one present at the clk edge that begins cycle n, so the ADC must hold data for at least 1 clk around the falling edge.
- busy rises one cycle after an accepted start. done rises and busy falls together, one cycle after the final write strobe.
- rd_data reflects the rd_addr presented one cycle earlier.
- Minimum adc_clk half-period: 2 clk cycles. Shorter high/low phases may drop strobes; this is not supported.

## Configuration
- ADC_CAPTURE_TRIG_EN defined:
  - trig_level port exists.
  - ARM writes nothing until a strobe where the previous strobed sample is < trig_level and the current sample is >= trig_level. That triggering sample is stored at address 0.
  - The first strobe after arming only records the previous sample.
- ADC_CAPTURE_TRIG_EN undefined: no trig_level port, and capture starts on the first strobe after start.

## Structure
- Package adc_pkg holds:
  - the FSM state enum (IDLE/ARM/CAPTURE);
  - default DATA_W and DEPTH constants;
  - a clamp function for the frame length.
- Sub-module adc_sample_ram is a simple dual-port RAM: one write port, one synchronous read port, read-old-on-collision. It is instantiated once.

## Test plan
All scenarios use DATA_W=12 and DEPTH=256.
- Basic frame: adc_clk toggles every 4 clk, adc_data ramps 0x100+k per sample, start with num_samples=16 -> addresses 0..15 hold 0x100..0x10F; done high about 16×8 clk later; wr_count=16; busy low.
- Clamp: num_samples=0, then num_samples=300 -> exactly 256 writes each time, wr_count=256, done high.
- Ignored start: a second start with num_samples=4 issued mid-frame of 32 -> 32 samples captured, frame length unchanged.
- Reset abort: assert rstn low after 5 samples -> busy=0, done=0, wr_count=0 immediately; a new start with num_samples=8 -> normal completion.
- Read latency and collision: rd_addr=3 after the frame -> rd_data equals sample 3 on the next cycle; a read of an address in the same cycle it is written -> old value.
- Trigger (with ADC_CAPTURE_TRIG_EN): trig_level=0x800, sine-like data crossing upward at a sample of value 0x805 -> address 0 = 0x805; no writes happen before the crossing.

Source files
------------

// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_pkg
// Description : Shared types and helpers for the ADC sample capture block.
//               Holds the capture FSM states, the default data width and
//               buffer depth, and the frame-length clamp function.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_DEPTH  = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  // A zero length, or one longer than the buffer, means "fill the buffer".
  function automatic int unsigned clamp_len(input int unsigned n,
                                            input int unsigned depth);
    return ((n == 0) || (n > depth)) ? depth : n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_sample_ram.sv
`default_nettype none
// ============================================================================
// Module      : adc_sample_ram
// Description : Simple dual-port sample buffer. One write port and one
//               registered read port. A read and a write to the same address
//               in the same cycle return the previous contents.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_sample_ram #(
  parameter  int DATA_W = 12,
  parameter  int DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; sees the pre-write contents on a same-address collision.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rdata <= '0;
    else       rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/adc_sample_capture.sv
`default_nettype none
// ============================================================================
// Module      : adc_sample_capture
// Description : Captures ADC conversion results into an on-chip buffer on
//               each falling edge of the generated ADC sample clock, then
//               flags a completed frame for readout.
//               Optional: ADC_CAPTURE_TRIG_EN adds an upward level trigger
//               that delays the first write until the data crosses
//               trig_level.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_sample_capture
  import adc_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              adc_clk,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              start,
  input  logic [ADDR_W:0]   num_samples,
`ifdef ADC_CAPTURE_TRIG_EN
  input  logic [DATA_W-1:0] trig_level,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  state_t            state;
  logic              adc_clk_q;
  logic [DATA_W-1:0] adc_data_q;
  logic [ADDR_W:0]   frame_len;
  logic [ADDR_W:0]   frame_len_in;
  logic [ADDR_W:0]   next_count;
  logic              samp_stb;
  logic              arm_hit;
  logic              we;
  logic [ADDR_W-1:0] waddr;

`ifdef ADC_CAPTURE_TRIG_EN
  logic [DATA_W-1:0] prev_sample;
  logic              have_prev;
`endif

  // Retime the ADC clock and data into clk before using them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      adc_clk_q  <= 1'b0;
      adc_data_q <= '0;
    end else begin
      adc_clk_q  <= adc_clk;
      adc_data_q <= adc_data;
    end
  end

  assign samp_stb     = adc_clk_q & ~adc_clk;
  assign frame_len_in = (ADDR_W+1)'(clamp_len(32'(num_samples), DEPTH));
  assign next_count   = wr_count + 1'b1;

`ifdef ADC_CAPTURE_TRIG_EN
  // Upward crossing: previous strobed sample below, current at or above.
  assign arm_hit = have_prev && (prev_sample < trig_level) &&
                   (adc_data_q >= trig_level);
`else
  assign arm_hit = 1'b1;
`endif

  // Write port: the first sample of a frame always lands at address 0.
  always_comb begin
    we    = samp_stb && (((state == ARM) && arm_hit) || (state == CAPTURE));
    waddr = (state == CAPTURE) ? wr_count[ADDR_W-1:0] : '0;
  end

  // Capture FSM with registered status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_count  <= '0;
      frame_len <= '0;
`ifdef ADC_CAPTURE_TRIG_EN
      prev_sample <= '0;
      have_prev   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            frame_len <= frame_len_in;
            wr_count  <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
            state     <= ARM;
`ifdef ADC_CAPTURE_TRIG_EN
            have_prev <= 1'b0;
`endif
          end
        end
        ARM: begin
          if (samp_stb) begin
`ifdef ADC_CAPTURE_TRIG_EN
            prev_sample <= adc_data_q;
            have_prev   <= 1'b1;
`endif
            if (arm_hit) begin
              wr_count <= (ADDR_W+1)'(1);
              if (frame_len == (ADDR_W+1)'(1)) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= CAPTURE;
              end
            end
          end
        end
        CAPTURE: begin
          if (samp_stb) begin
            wr_count <= next_count;
            if (next_count == frame_len) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  adc_sample_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (we),
    .waddr (waddr),
    .wdata (adc_data_q),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_sample_capture
// Description : Directed bench for adc_sample_capture: frame lengths from a
//               table, then hand-written ignored-start, reset-abort, read
//               latency/collision and (with ADC_CAPTURE_TRIG_EN) trigger runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_sample_capture;

  localparam int DW    = 12;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
`ifdef ADC_CAPTURE_TRIG_EN
  // The trigger consumes one strobe before the crossing sample is stored.
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif

  logic          clk;
  logic          rstn;
  logic          adc_clk;
  logic [DW-1:0] adc_data;
  logic          start;
  logic [AW:0]   num_samples;
  logic [DW-1:0] trig_level;
  logic          busy;
  logic          done;
  logic [AW:0]   wr_count;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  int total = 0;
  int bad   = 0;

  // Stimulus generator controls
  logic gen_en = 1'b0;
  int   mode   = 0;
  int   base   = 0;
  int   idx    = 0;
  int   ph     = 0;

  int trig_tab [8] = '{12'h900, 12'h700, 12'h600, 12'h7F0,
                       12'h805, 12'h900, 12'hA00, 12'hB00};

  adc_sample_capture #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .adc_clk     (adc_clk),
    .adc_data    (adc_data),
    .start       (start),
    .num_samples (num_samples),
`ifdef ADC_CAPTURE_TRIG_EN
    .trig_level  (trig_level),
`endif
    .busy        (busy),
    .done        (done),
    .wr_count    (wr_count),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int sample_value(input int k);
    if (mode == 1) return (k < 8) ? trig_tab[k] : 12'hC00;
    return (base + k) & 12'hFFF;
  endfunction

  // Expected buffer word at address a for the frame just captured.
  function automatic int exp_val(input int a);
    if (mode == 1) return (a + 4 < 8) ? trig_tab[a + 4] : 12'hC00;
    return (base + a + OFS) & 12'hFFF;
  endfunction

  // ADC model: half-period of 4 clk, new data presented on the rising edge.
  initial begin
    adc_clk  = 1'b0;
    adc_data = '0;
    forever begin
      @(posedge clk);
      #3;
      if (!gen_en) begin
        adc_clk = 1'b0;
        ph      = 0;
        idx     = 0;
      end else begin
        ph++;
        if (ph == 4) begin
          ph      = 0;
          adc_clk = ~adc_clk;
          if (adc_clk) begin
            adc_data = DW'(sample_value(idx));
            idx++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_start(input int n, input int b);
    @(posedge clk); #1;
    gen_en     = 1'b0;
    base       = b;
    trig_level = DW'(b + 1);
    repeat (2) @(posedge clk);
    #1;
    start       = 1'b1;
    num_samples = (AW+1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", int'(busy), 1);
    check("start_done", int'(done), 0);
    check("start_count", int'(wr_count), 0);
    gen_en = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (!done && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check("done_timeout", int'(done), 1);
  endtask

  task automatic wait_count(input int target, input int budget);
    int c = 0;
    while (int'(wr_count) < target && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check("count_timeout", int'(wr_count) >= target ? 1 : 0, 1);
  endtask

  task automatic check_frame(input int n);
    int errs = 0;
    check("frame_count", int'(wr_count), n);
    check("frame_busy", int'(busy), 0);
    check("frame_done", int'(done), 1);
    for (int a = 0; a < n; a++) begin
      @(posedge clk); #1;
      rd_addr = AW'(a);
      @(posedge clk); #1;
      if (int'(rd_data) != exp_val(a)) errs++;
    end
    check("frame_data_errs", errs, 0);
  endtask

  typedef struct {
    int n;
    int exp_n;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int c;
    vecs[0] = '{16, 16};
    vecs[1] = '{0, 256};
    vecs[2] = '{300, 256};
    vecs[3] = '{1, 1};
    vecs[4] = '{8, 8};

    rstn        = 1'b0;
    start       = 1'b0;
    num_samples = '0;
    trig_level  = '0;
    rd_addr     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_count", int'(wr_count), 0);
    check("rst_rdata", int'(rd_data), 0);
    rstn = 1'b1;

    // Table-driven frame lengths, including both clamp cases and length 1.
    for (int i = 0; i < 5; i++) begin
      do_start(vecs[i].n, 12'h100);
      wait_done(vecs[i].exp_n * 8 + 64);
      check_frame(vecs[i].exp_n);
    end

    // A start during capture must not change the frame length.
    do_start(32, 12'h200);
    wait_count(10, 200);
    @(posedge clk); #1;
    start       = 1'b1;
    num_samples = (AW+1)'(4);
    @(posedge clk); #1;
    start = 1'b0;
    check("ign_busy", int'(busy), 1);
    wait_done(32 * 8 + 64);
    check_frame(32);

    // Reset mid-frame aborts immediately, then a fresh frame completes.
    do_start(64, 12'h100);
    wait_count(5, 200);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_count", int'(wr_count), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    do_start(8, 12'h400);
    wait_done(8 * 8 + 64);
    check_frame(8);

    // One-cycle read latency.
    @(posedge clk); #1;
    rd_addr = AW'(7);
    @(posedge clk); #1;
    rd_addr = AW'(3);
    #1;
    check("rd_hold", int'(rd_data), exp_val(7));
    @(posedge clk); #1;
    check("rd_latency", int'(rd_data), exp_val(3));

    // Collision: address 3 written while it is being read returns old data.
    do_start(16, 12'h500);
    c = 0;
    while (int'(wr_count) != 4 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    check("coll_reach", int'(wr_count), 4);
    check("coll_old", int'(rd_data), (12'h403 + OFS) & 12'hFFF);
    @(posedge clk); #1;
    check("coll_new", int'(rd_data), exp_val(3));
    wait_done(16 * 8 + 64);
    check_frame(16);

`ifdef ADC_CAPTURE_TRIG_EN
    // Upward crossing of 0x800 happens at sample 0x805.
    mode = 1;
    do_start(4, 12'h7FF);
    c = 0;
    while (idx < 5 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    check("trig_pre_count", int'(wr_count), 0);
    check("trig_pre_busy", int'(busy), 1);
    wait_done(4 * 8 + 64);
    check_frame(4);
    mode = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
